// File: rtl/io_regs_responder.sv
// rtl/io_regs_responder.sv - NREG x 32-bit register-bank responder on the I/O bridge bus (optional IO_REGS_STALL_EN)
module io_regs_responder #(
   parameter logic [31:0] BASE    = 32'hFD0C0000,
   parameter logic [31:0] MASK    = 32'hFFFFFF00,
   parameter int          NREG    = 8,
   parameter int          WAIT    = 1,
   parameter logic [31:0] RST_VAL = 32'h0
) (
   input  logic                 rst_i,
   input  logic                 clk_i,
   input  logic                 s_cyc_i,
   input  logic                 s_stb_i,
   output logic                 s_ack_o,
   output logic                 s_stall_o,
   input  logic                 s_we_i,
   input  logic [3:0]           s_sel_i,
   input  logic [31:0]          s_adr_i,
   input  logic [31:0]          s_dat_i,
   output logic [31:0]          s_dat_o,
   input  logic [31:0]          stat_i,
   output logic [NREG*32-1:0]   regs_o
);

   localparam int IW = $clog2(NREG);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ACK    = 2'd3;

   localparam logic [3:0] WAIT_LD = 4'(WAIT);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   rdat_q, rdat_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic          stall_q, stall_d;
   logic [31:0]   regs_q [NREG];
   logic [31:0]   regs_d [NREG];

   logic          hit;

   // Address window decode: bits outside MASK alias onto the same registers.
   assign hit = s_cyc_i & s_stb_i & ((s_adr_i & MASK) == BASE);

   // Access sequencing: capture, wait states, single-cycle commit, then ack until the strobe drops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      dat_d   = 32'h0;
      for (int k = 0; k < NREG; k++) begin
         regs_d[k] = regs_q[k];
      end

      case (state_q)
         ST_IDLE: begin
            if (hit) begin
               we_d    = s_we_i;
               sel_d   = s_sel_i;
               idx_d   = s_adr_i[2 +: IW];
               wdat_d  = s_dat_i;
               cnt_d   = WAIT_LD;
               state_d = (WAIT == 0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!s_cyc_i) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_ACCESS;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: begin
            if (!s_cyc_i) begin
               state_d = ST_IDLE;
            end else begin
               if (we_q) begin
                  // Register 0 is the status word, so a write to it is acked but discarded.
                  if (idx_q != '0) begin
                     for (int b = 0; b < 4; b++) begin
                        if (sel_q[b]) begin
                           regs_d[idx_q][8*b +: 8] = wdat_q[8*b +: 8];
                        end
                     end
                  end
                  rdat_d = 32'h0;
               end else begin
                  rdat_d = (idx_q == '0) ? stat_i : regs_q[idx_q];
               end
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (s_cyc_i & s_stb_i) begin
               ack_d = 1'b1;
               dat_d = rdat_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef IO_REGS_STALL_EN
      stall_d = (state_d != ST_IDLE);
`else
      stall_d = 1'b0;
`endif
   end

   // State, capture and register-bank flops; reset drops any access in flight without committing it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         idx_q   <= '0;
         wdat_q  <= 32'h0;
         rdat_q  <= 32'h0;
         ack_q   <= 1'b0;
         dat_q   <= 32'h0;
         stall_q <= 1'b0;
         regs_q[0] <= 32'h0;
         for (int k = 1; k < NREG; k++) begin
            regs_q[k] <= RST_VAL;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         stall_q <= stall_d;
         for (int k = 0; k < NREG; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   // Flatten the bank; slot 0 is the status position and always reads as zero here.
   always_comb begin
      regs_o = '0;
      for (int k = 1; k < NREG; k++) begin
         regs_o[k*32 +: 32] = regs_q[k];
      end
   end

   assign s_ack_o   = ack_q;
   assign s_dat_o   = dat_q;
   assign s_stall_o = stall_q;

endmodule
